// File: rtl/sd_cmd_responder_if.sv
// User-side handshake bundle for sd_cmd_responder: received-command report
// and response request. The slave modport is the responder, the master is the user logic.
interface sd_cmd_responder_if;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        cmd_crc_err;
  logic        resp_valid;
  logic        resp_none;
  logic [5:0]  resp_index;
  logic [31:0] resp_status;
  logic        busy;

  modport master (
    input  cmd_valid, cmd_index, cmd_arg, cmd_crc_err, busy,
    output resp_valid, resp_none, resp_index, resp_status
  );

  modport slave (
    output cmd_valid, cmd_index, cmd_arg, cmd_crc_err, busy,
    input  resp_valid, resp_none, resp_index, resp_status
  );
endinterface

// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD line responder: receives 48-bit command tokens and returns a
// user-supplied 48-bit response. Define SD_CMD_RESP_CRC_CHECK_EN for receive CRC7 checking.
module sd_cmd_responder #(
  parameter int NCR = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sd_clk_in,
  input  logic              cmd_in,
  output logic              cmd_out,
  output logic              cmd_oe,
  sd_cmd_responder_if.slave usr
);

  // state     | meaning
  // IDLE      | waiting for a start bit on CMD
  // RX        | shifting in the remaining 47 command bits
  // WAIT_USER | command reported, waiting for resp_valid / resp_none
  // GAP       | response latched, holding CMD released until NCR periods passed
  // TX        | driving the 48-bit response, one bit per SD falling edge
  typedef enum logic [2:0] {IDLE, RX, WAIT_USER, GAP, TX} state_t;
  state_t state, state_nxt;

  logic [1:0]  sd_sync, cmd_sync;
  logic        sd_prev, sd_rise, sd_fall, cmd_bit;
  logic [5:0]  rx_cnt, tx_cnt;
  logic [37:0] rx_sr;
  logic [47:0] tx_sr;
  logic [6:0]  gap_cnt;
  logic        gap_done, frame_ok, resp_take, tx_start, tx_shift, tx_end;

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  // cmd sync resets to 1 so a released bus never looks like a start bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sd_sync  <= 2'b00;
      cmd_sync <= 2'b11;
      sd_prev  <= 1'b0;
    end else begin
      sd_sync  <= {sd_sync[0], sd_clk_in};
      cmd_sync <= {cmd_sync[0], cmd_in};
      sd_prev  <= sd_sync[1];
    end
  end

  assign sd_rise  = sd_sync[1] & ~sd_prev;
  assign sd_fall  = ~sd_sync[1] & sd_prev;
  assign cmd_bit  = cmd_sync[1];
  assign gap_done = (gap_cnt >= 7'(NCR));
  assign usr.busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    frame_ok  = 1'b0;
    resp_take = 1'b0;
    tx_start  = 1'b0;
    tx_shift  = 1'b0;
    tx_end    = 1'b0;
    case (state)
      IDLE: if (sd_rise && !cmd_bit) state_nxt = RX;
      RX: if (sd_rise) begin
        if (rx_cnt == 6'd1 && !cmd_bit) state_nxt = IDLE;
        else if (rx_cnt == 6'd47) begin
          if (cmd_bit) begin
            state_nxt = WAIT_USER;
            frame_ok  = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      WAIT_USER: begin
        if (usr.resp_none) state_nxt = IDLE;
        else if (usr.resp_valid) begin
          state_nxt = GAP;
          resp_take = 1'b1;
        end
      end
      GAP: if (sd_fall && gap_done) begin
        state_nxt = TX;
        tx_start  = 1'b1;
      end
      TX: if (sd_fall) begin
        if (tx_cnt == 6'd48) begin
          state_nxt = IDLE;
          tx_end    = 1'b1;
        end else begin
          tx_shift = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // rx_cnt k holds frame bit 47-k; only index and argument bits are kept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_cnt <= '0;
      rx_sr  <= '0;
    end else if (sd_rise) begin
      if (state == IDLE) rx_cnt <= 6'd1;
      else if (state == RX) begin
        rx_cnt <= rx_cnt + 6'd1;
        if (rx_cnt >= 6'd2 && rx_cnt <= 6'd39) rx_sr <= {rx_sr[36:0], cmd_bit};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      usr.cmd_valid <= 1'b0;
      usr.cmd_index <= '0;
      usr.cmd_arg   <= '0;
    end else begin
      usr.cmd_valid <= frame_ok;
      if (frame_ok) begin
        usr.cmd_index <= rx_sr[37:32];
        usr.cmd_arg   <= rx_sr[31:0];
      end
    end
  end

`ifdef SD_CMD_RESP_CRC_CHECK_EN
  logic [6:0] crc_rx;

  // start and transmission bits are implied 0/1 once a frame is accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc_rx          <= '0;
      usr.cmd_crc_err <= 1'b0;
    end else begin
      if (state == RX && sd_rise && rx_cnt >= 6'd40 && rx_cnt <= 6'd46)
        crc_rx <= {crc_rx[5:0], cmd_bit};
      if (frame_ok) usr.cmd_crc_err <= (crc7({2'b01, rx_sr}) != crc_rx);
    end
  end
`else
  assign usr.cmd_crc_err = 1'b0;
`endif

  // counts SD rising edges after the end bit, saturating once NCR is reached
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) gap_cnt <= '0;
    else if (frame_ok) gap_cnt <= '0;
    else if (sd_rise && state != IDLE && state != RX && !gap_done)
      gap_cnt <= gap_cnt + 7'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_sr   <= '0;
      tx_cnt  <= '0;
      cmd_oe  <= 1'b0;
      cmd_out <= 1'b1;
    end else begin
      if (resp_take)
        tx_sr <= {2'b00, usr.resp_index, usr.resp_status,
                  crc7({2'b00, usr.resp_index, usr.resp_status}), 1'b1};
      else if (tx_start || tx_shift)
        tx_sr <= {tx_sr[46:0], 1'b0};
      if (tx_start)      tx_cnt <= 6'd1;
      else if (tx_shift) tx_cnt <= tx_cnt + 6'd1;
      if (tx_start || tx_shift) begin
        cmd_oe  <= 1'b1;
        cmd_out <= tx_sr[47];
      end else if (tx_end) begin
        cmd_oe  <= 1'b0;
        cmd_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Self-checking bench for sd_cmd_responder: host-side SD clock/CMD stimulus,
// a user-side responder process and a polynomial-division CRC7 reference.
module tb_sd_cmd_responder;
  localparam int NCR  = 2;
  localparam int HALF = 8;
  localparam int PRE  = 2;
  localparam int E    = PRE + 47;
`ifdef SD_CMD_RESP_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sd_clk_in = 1'b0;
  logic cmd_in = 1'b1;
  logic cmd_out, cmd_oe;

  sd_cmd_responder_if u_if ();

  sd_cmd_responder #(.NCR(NCR)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sd_clk_in (sd_clk_in),
    .cmd_in    (cmd_in),
    .cmd_out   (cmd_out),
    .cmd_oe    (cmd_oe),
    .usr       (u_if)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_checks = 0;
  int cyc = 0;
  logic oe_log [0:255];
  logic out_log [0:255];
  int vcount = 0;
  logic [5:0] last_idx;
  logic [31:0] last_arg;
  logic last_err;
  int pend = 0;
  int mode = 0;
  logic stray_now = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // remainder of M(x)*x^7 divided by x^7+x^3+1
  function automatic logic [6:0] ref_crc7(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r = r ^ (47'h89 << (i - 7));
    return r[6:0];
  endfunction

  function automatic logic [47:0] make_tok(input logic [5:0] idx, input logic [31:0] arg,
                                           input logic [6:0] crc_xor, input logic end_bad);
    logic [39:0] m;
    m = {2'b01, idx, arg};
    return {m, ref_crc7(m) ^ crc_xor, ~end_bad};
  endfunction

  // user logic: answers each cmd_valid after 1..3 clocks according to mode
  // (0 = resp_none, 1 = resp_valid, 2 = both together)
  task automatic user_step();
    u_if.resp_valid = 1'b0;
    u_if.resp_none  = 1'b0;
    if (stray_now) begin
      u_if.resp_valid = 1'b1;
      u_if.resp_none  = 1'($urandom_range(0, 1));
      stray_now = 1'b0;
    end else if (u_if.cmd_valid) begin
      vcount++;
      last_idx = u_if.cmd_index;
      last_arg = u_if.cmd_arg;
      last_err = u_if.cmd_crc_err;
      pend = 1 + $urandom_range(0, 2);
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        u_if.resp_none  = (mode != 1);
        u_if.resp_valid = (mode != 0);
      end
    end
  endtask

  task automatic sd_cycle(input logic b);
    sd_clk_in = 1'b0;
    cmd_in = b;
    for (int k = 0; k < HALF; k++) begin @(negedge clk); user_step(); end
    oe_log[cyc]  = cmd_oe;
    out_log[cyc] = cmd_out;
    cyc++;
    sd_clk_in = 1'b1;
    for (int k = 0; k < HALF; k++) begin @(negedge clk); user_step(); end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) sd_cycle(1'b1);
  endtask

  task automatic send_token(input logic [47:0] tok);
    for (int i = 47; i >= 0; i--) sd_cycle(tok[i]);
  endtask

  task automatic run_txn(input logic [47:0] tok, input int md, input logic [5:0] ri,
                         input logic [31:0] rs, input logic exp_valid, input logic exp_err,
                         input logic stray, input string tag);
    int v0, first, ones, exp_first;
    logic [47:0] got, exp_r;
    logic exp_tx;
    mode = md;
    u_if.resp_index  = ri;
    u_if.resp_status = rs;
    stray_now = stray;
    v0 = vcount;
    cyc = 0;
    idle_cycles(PRE);
    send_token(tok);
    idle_cycles(NCR + 54);
    exp_tx = exp_valid && (md == 1);
    chk({tag, "_valid"}, 64'(vcount - v0), 64'(exp_valid));
    if (exp_valid) begin
      chk({tag, "_index"}, 64'(last_idx), 64'(tok[45:40]));
      chk({tag, "_arg"}, 64'(last_arg), 64'(tok[39:8]));
      chk({tag, "_crc_err"}, 64'(last_err), 64'(exp_err));
    end
    first = -1;
    ones = 0;
    for (int c = 0; c < cyc; c++)
      if (oe_log[c]) begin
        if (first < 0) first = c;
        ones++;
      end
    exp_first = exp_tx ? (E + NCR + 1) : -1;
    chk({tag, "_oe_first"}, 64'(first), 64'(exp_first));
    chk({tag, "_oe_len"}, 64'(ones), exp_tx ? 64'd48 : 64'd0);
    if (exp_tx) begin
      got = '0;
      for (int k = 0; k < 48; k++) got[47 - k] = out_log[E + NCR + 1 + k];
      exp_r = {2'b00, ri, rs, ref_crc7({2'b00, ri, rs}), 1'b1};
      chk({tag, "_resp"}, 64'(got), 64'(exp_r));
    end
    chk({tag, "_busy_end"}, 64'(u_if.busy), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [47:0] tok, exp_r;
    logic [5:0] ci;
    logic [31:0] ca;
    logic cbad, ebad;
    int md, v0, ones;

    u_if.resp_valid  = 1'b0;
    u_if.resp_none   = 1'b0;
    u_if.resp_index  = '0;
    u_if.resp_status = '0;
    repeat (4) @(negedge clk);
    chk("rst_cmd_oe", 64'(cmd_oe), 64'd0);
    chk("rst_cmd_out", 64'(cmd_out), 64'd1);
    chk("rst_cmd_valid", 64'(u_if.cmd_valid), 64'd0);
    chk("rst_cmd_index", 64'(u_if.cmd_index), 64'd0);
    chk("rst_cmd_arg", 64'(u_if.cmd_arg), 64'd0);
    chk("rst_crc_err", 64'(u_if.cmd_crc_err), 64'd0);
    chk("rst_busy", 64'(u_if.busy), 64'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    run_txn(48'h40_00000000_95, 0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b1, "cmd0");
    run_txn(48'h48_000001AA_87, 1, 6'd8, 32'h0000_01AA, 1'b1, 1'b0, 1'b0, "cmd8");
    run_txn(48'h51_00000000_57, 0, 6'd0, 32'd0, 1'b1, CRC_EN, 1'b0, "cmd17_badcrc");

    // transmission bit 0: frame abandoned right after that bit
    mode = 0;
    cyc = 0;
    v0 = vcount;
    tok = 48'h00_00000000_95;
    idle_cycles(PRE);
    sd_cycle(tok[47]);
    sd_cycle(tok[46]);
    chk("badtx_busy", 64'(u_if.busy), 64'd0);
    for (int i = 45; i >= 0; i--) sd_cycle(tok[i]);
    chk("badtx_valid", 64'(vcount - v0), 64'd0);
    ones = 0;
    for (int c = 0; c < cyc; c++) if (oe_log[c]) ones++;
    chk("badtx_oe", 64'(ones), 64'd0);
    cyc = 0;
    idle_cycles(64);

    run_txn(48'h40_00000000_95, 2, 6'd3, 32'h1234_5678, 1'b1, 1'b0, 1'b0, "both_pulse");

    // reset while the response is on the line
    mode = 1;
    u_if.resp_index  = 6'd8;
    u_if.resp_status = 32'h0000_01AA;
    cyc = 0;
    idle_cycles(PRE);
    send_token(48'h48_000001AA_87);
    idle_cycles(NCR + 21);
    exp_r = {2'b00, 6'd8, 32'h0000_01AA, ref_crc7({2'b00, 6'd8, 32'h0000_01AA}), 1'b1};
    chk("rst_tx_on", 64'(oe_log[cyc - 1]), 64'd1);
    chk("rst_tx_bit20", 64'(out_log[cyc - 1]), 64'(exp_r[27]));
    reset_n = 1'b0;
    #1;
    chk("rst_oe_async", 64'(cmd_oe), 64'd0);
    chk("rst_out_async", 64'(cmd_out), 64'd1);
    chk("rst_busy_async", 64'(u_if.busy), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    run_txn(48'h40_00000000_95, 1, 6'($urandom), $urandom, 1'b1, 1'b0, 1'b0, "post_rst");

    for (int t = 0; t < 10; t++) begin
      ci   = 6'($urandom);
      ca   = $urandom;
      cbad = ($urandom_range(0, 3) == 0);
      ebad = ($urandom_range(0, 7) == 0);
      md   = $urandom_range(0, 2);
      tok  = make_tok(ci, ca, cbad ? (7'h1 << $urandom_range(0, 6)) : 7'h0, ebad);
      run_txn(tok, md, 6'($urandom), $urandom, !ebad, CRC_EN && cbad,
              1'($urandom_range(0, 1)), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/sd_cmd_responder.md
SD_CMD_RESPONDER -- requirements
Module: sd_cmd_responder

Interface
REQ-001 SHALL have parameter NCR, default 2, meaning minimum SD-clock periods from command end bit to response start bit (legal 2..64).
REQ-002 SHALL have clk  input  1  system clock (MAX10_CLK1_50 domain); the block's only clock.
REQ-003 SHALL have reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have sd_clk_in  input  1  host SD clock, asynchronous, sampled by clk.
REQ-005 SHALL have cmd_in  input  1  host CMD line as seen by the card.
REQ-006 SHALL have cmd_out  output  1  card-driven CMD value.
REQ-007 SHALL have cmd_oe  output  1  CMD output enable, 1 = card drives the line.
REQ-008 SHALL have cmd_valid  output  1  one-clk pulse, command token received.
REQ-009 SHALL have cmd_index  output  6  received command index.
REQ-010 SHALL have cmd_arg  output  32  received argument.
REQ-011 SHALL have cmd_crc_err  output  1  CRC7 mismatch flag, valid with cmd_valid.
REQ-012 SHALL have resp_valid  input  1  user supplies a 48-bit response, one-clk pulse.
REQ-013 SHALL have resp_none  input  1  user declares no response, one-clk pulse.
REQ-014 SHALL have resp_index  input  6  response index field.
REQ-015 SHALL have resp_status  input  32  response card-status field.
REQ-016 SHALL have busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL pass sd_clk_in and cmd_in through matched 2-FF synchronizers; rise/fall derived from synchronized sd_clk; clk >= 8x SD clock.
REQ-018 SHALL sample cmd_in only on detected SD rising edges; cmd_out/cmd_oe change only on detected SD falling edges.
REQ-019 SHALL implement states IDLE, RX, WAIT_USER, GAP, TX.
REQ-020 IDLE: sampled 0 -> RX with bit count 1; sampled 1 -> stay.
REQ-021 RX: shift 47 more bits; bit 46 (transmission) must be 1, else return to IDLE without cmd_valid.
REQ-022 After bit 0, end bit must be 1, else return to IDLE without cmd_valid.
REQ-023 On valid frame: cmd_index = bits[45:40], cmd_arg = bits[39:8], cmd_valid pulses one clk, -> WAIT_USER.
REQ-024 CRC7: polynomial x^7+x^3+1, init 0, over bits[47:8]; compared with bits[7:1].
REQ-025 GAP counter starts at the end bit and counts SD rising edges in every state after RX.
REQ-026 WAIT_USER: resp_none -> IDLE; resp_valid -> latch fields, -> GAP; both same cycle -> resp_none wins; neither -> wait indefinitely.
REQ-027 GAP: hold cmd_oe=0 until NCR SD periods have elapsed since the end bit, then -> TX; if already elapsed, TX at the next falling edge.
REQ-028 TX: drive 0, 0, resp_index[5:0], resp_status[31:0], CRC7 over preceding 40 bits, 1, MSB first, one bit per falling edge.
REQ-029 After the end bit's period, at the next falling edge: cmd_oe=0, cmd_out=1, -> IDLE.
REQ-030 resp_valid/resp_none outside WAIT_USER SHALL be ignored.
REQ-031 cmd_in SHALL be ignored during GAP and TX.
REQ-032 No SD edges for any duration: state frozen, no timeout.

Reset
REQ-033 Reset values: state IDLE, cmd_oe 0, cmd_out 1, cmd_valid 0, cmd_index 0, cmd_arg 0, cmd_crc_err 0, busy 0, counters and synchronizers 0 (sd_clk sync) / 1 (cmd sync).
REQ-034 Reset mid-TX SHALL release CMD (cmd_oe 0) immediately and asynchronously; no partial resumption after release.

Configuration
REQ-035 Macro SD_CMD_RESP_CRC_CHECK_EN defined: CRC7 check per REQ-024; mismatch sets cmd_crc_err with cmd_valid, and the block still enters WAIT_USER.
REQ-036 Macro undefined: no receive CRC logic; cmd_crc_err tied 0. Response CRC generation is always present.

Verification
REQ-037 Token 0x40_00000000_95 (CMD0) -> cmd_valid, cmd_index 0, cmd_arg 0, cmd_crc_err 0.
REQ-038 Token 0x48_000001AA_87 then resp_valid (index 8, status 0x000001AA) -> TX starts NCR=2 periods after end bit; 48 bits match reference CRC7 model.
REQ-039 Token 0x51_00000000_57 (CRC wrong, correct 0x55) with macro -> cmd_crc_err 1; without macro -> 0.
REQ-040 Token with transmission bit 0 (0x00_00000000_95) -> no cmd_valid, busy returns 0, cmd_oe stays 0.
REQ-041 CMD0 then resp_none and resp_valid in the same clk -> no TX, IDLE, cmd_oe 0 throughout.
REQ-042 reset_n low at TX bit 20 -> cmd_oe 0 the same clk; next valid token is received normally.
